booth4_iter_mult: RTL and testbench
===================================

# booth4_iter_mult

Iterative radix-4 (modified Booth) multiplier, parametrised in operand width, with runtime signed/unsigned mode and valid/ready handshakes on both sides. It retires one Booth digit per clock into a single accumulator, so area is one partial-product generator plus one adder. It is the area-optimised sibling of the Wallace-tree multiplier: it shares the Booth digit encoding and partial-product generation, but replaces the tree with sequential accumulation.

## Interface
- `WIDTH`, default 16: operand width; must be even and ≥ 4.
- `sys_clk`  in  1  clock; all state updates on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and mode valid.
- `in_ready`  out  1  block can accept operands.
- `is_signed`  in  1  1 = two's-complement operands; 0 = unsigned operands.
- `A`  in  WIDTH  multiplicand.
- `B`  in  WIDTH  multiplier (Booth-encoded operand).
- `out_valid`  out  1  `prod` is valid.
- `out_ready`  in  1  consumer accepts `prod`.
- `prod`  out  2*WIDTH  product of `A` and `B`.
- `busy`  out  1  high in state BUSY.

## Operation
- Constant K = WIDTH/2 + 1 Booth digits per operation, in both signed and unsigned mode.
- Operand extension at accept, per `is_signed`:
  - A_ext is `A` extended to WIDTH+2 bits (sign-extended if signed, zero-extended if unsigned).
  - B_ext is `B` extended to WIDTH+2 bits the same way, with an implicit 0 appended below bit 0.
- Digit k (k = 0..K-1) is formed from B_ext bits [2k+1 : 2k-1]. Encoding:
  - 000 and 111 → 0
  - 001 and 010 → +1
  - 011 → +2
  - 100 → −2
  - 101 and 110 → −1
- Partial product pp_k = d_k·A_ext, a WIDTH+2-bit two's-complement value:
  - +2 is a left shift by 1.
  - Negation is ~A_ext + 1, so A = 2^(WIDTH−1) in signed mode is exact.
- Accumulation: ACC += sign-extend(pp_k) << 2k, computed mod 2^(2·WIDTH). `prod` = ACC. The true product always fits in 2·WIDTH bits, so the truncation is exact.
- FSM states:
  - IDLE: `in_ready` = 1. On `in_valid` & `in_ready`: latch A_ext, B_ext and mode; ACC ← 0; cnt ← 0; go to BUSY.
  - BUSY: each edge adds pp_cnt and increments cnt. On the edge where cnt = K−1, go to DONE.
  - DONE: `out_valid` = 1 and `prod` is held stable. On `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. Operands on `A`/`B` may change freely after the accept edge.
- Reset values: state = IDLE, ACC = 0, cnt = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1 (in the cycle after reset deasserts).
- Reset during BUSY or DONE: the operation is aborted and no output is produced. `sys_rst` takes priority over every handshake in the same cycle.
- A zero multiplier (B = 0) still takes the full K-cycle schedule; there is no early termination.

## Timing
- Accept edge E0. Digits are processed on edges E1..EK. `out_valid` is high from the cycle after EK.
- Latency from accept to `out_valid` is K+1 edges; for WIDTH = 16 this is 10.
- Minimum issue interval is K+2 cycles: the DONE handshake edge, then the IDLE accept edge.
- `out_valid` and `prod` are registered outputs.
- `in_ready` is a pure decode of state (state = IDLE); it has no combinational dependence on inputs.
- Backpressure: while `out_ready` = 0 in DONE, `out_valid` stays 1 and `prod` is unchanged, for an unbounded time.

## Structure
- Package `booth4_pkg` holds:
  - the digit code localparams: BOOTH_ZERO, BOOTH_POS1, BOOTH_POS2, BOOTH_NEG1, BOOTH_NEG2;
  - the state encoding: ST_IDLE, ST_BUSY, ST_DONE;
  - the function for K.
- Sub-module `booth4_pp_gen #(WIDTH)`: combinational. Takes a 3-bit code and A_ext; produces a WIDTH+2-bit signed partial product. It is instantiated once; the top level owns the FSM, the counter, the shifted accumulation and the handshakes.

## Test plan
- Signed mode, A = 0x5C0B, B = 0x0003 → `prod` = 0x0001_1421, with `out_valid` exactly 10 cycles after the accept edge.
- Signed boundary cases:
  - A = 0x8000, B = 0x8000 → 0x4000_0000.
  - A = 0x8000, B = 0x7FFF → 0xC000_8000.
- Unsigned mode, A = 0xFFFF, B = 0xFFFF → 0xFFFE_0001. Repeat the same operands in signed mode → 0x0000_0001.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE while toggling `in_valid` and `A`/`B`. Required: `prod` stable, `in_ready` = 0, exactly one output transfer. Then accept the next operation.
- Assert `sys_rst` for one cycle when cnt = 4. Required:
  - next cycle: state IDLE, `out_valid` = 0, `in_ready` = 1;
  - a following op with A = 0x1234, B = 0 yields 0 after the full 10-cycle latency.
- Back-to-back operations with `out_ready` tied high: the issue interval is 11 cycles (K+2), and every result matches the reference product.

Source files
------------

// File: rtl/booth4_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier: digit codes,
// FSM state encoding and the digit-count helper.
package booth4_pkg;

    localparam logic [2:0] BOOTH_ZERO = 3'd0;
    localparam logic [2:0] BOOTH_POS1 = 3'd1;
    localparam logic [2:0] BOOTH_POS2 = 3'd2;
    localparam logic [2:0] BOOTH_NEG1 = 3'd3;
    localparam logic [2:0] BOOTH_NEG2 = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One extra digit covers the two guard bits of the extended multiplier.
    function automatic int booth_digits(input int width);
        return (width / 2) + 1;
    endfunction

    function automatic logic [2:0] booth_encode(input logic [2:0] triplet);
        logic [2:0] code;
        case (triplet)
            3'b000:  code = BOOTH_ZERO;
            3'b001:  code = BOOTH_POS1;
            3'b010:  code = BOOTH_POS1;
            3'b011:  code = BOOTH_POS2;
            3'b100:  code = BOOTH_NEG2;
            3'b101:  code = BOOTH_NEG1;
            3'b110:  code = BOOTH_NEG1;
            3'b111:  code = BOOTH_ZERO;
            default: code = BOOTH_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth4_pp_gen.sv
// Combinational Booth partial-product generator: maps a digit code and the
// extended multiplicand to a WIDTH+2-bit two's-complement partial product.
module booth4_pp_gen
    import booth4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       i_code,
    input  logic [WIDTH+1:0] i_a_ext,
    output logic [WIDTH+1:0] o_pp
);

    localparam logic [WIDTH+1:0] PP_ZERO = {(WIDTH + 2){1'b0}};
    localparam logic [WIDTH+1:0] PP_ONE  = {{(WIDTH + 1){1'b0}}, 1'b1};

    logic [WIDTH+1:0] w_a2;

    assign w_a2 = {i_a_ext[WIDTH:0], 1'b0};

    // Digit select; negation via invert-plus-one keeps the most negative operand exact.
    always_comb begin
        o_pp = PP_ZERO;
        case (i_code)
            BOOTH_ZERO: o_pp = PP_ZERO;
            BOOTH_POS1: o_pp = i_a_ext;
            BOOTH_POS2: o_pp = w_a2;
            BOOTH_NEG1: o_pp = ~i_a_ext + PP_ONE;
            BOOTH_NEG2: o_pp = ~w_a2 + PP_ONE;
            default:    o_pp = PP_ZERO;
        endcase
    end

endmodule

// File: rtl/booth4_iter_mult.sv
// Iterative radix-4 Booth multiplier: one digit per clock into a single
// accumulator, valid/ready handshakes on operand and product sides.
module booth4_iter_mult
    import booth4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy
);

    localparam int K  = booth_digits(WIDTH);
    localparam int CW = $clog2(K) + 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       r_state;
    logic [WIDTH+1:0] r_a;
    logic [WIDTH+2:0] r_b;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;

    logic [WIDTH+1:0] w_a_ext;
    logic [WIDTH+1:0] w_b_ext;
    logic [2:0]       w_code;
    logic [WIDTH+1:0] w_pp;
    logic [PW-1:0]    w_pp_wide;
    logic [CW:0]      w_shamt;
    logic [PW-1:0]    w_addend;

    assign w_a_ext = is_signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
    assign w_b_ext = is_signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

    // r_b is shifted down two bits per digit, so the current triplet is always r_b[2:0].
    assign w_code    = booth_encode(r_b[2:0]);
    assign w_pp_wide = {{(PW - WIDTH - 2){w_pp[WIDTH+1]}}, w_pp};
    assign w_shamt   = {r_cnt, 1'b0};
    assign w_addend  = w_pp_wide << w_shamt;

    booth4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .i_code  (w_code),
        .i_a_ext (r_a),
        .o_pp    (w_pp)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_BUSY);
    assign out_valid = r_out_valid;
    assign prod      = r_acc;

    // Control FSM, digit counter and shifted accumulation.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_a         <= {(WIDTH + 2){1'b0}};
            r_b         <= {(WIDTH + 3){1'b0}};
            r_acc       <= {PW{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= w_a_ext;
                        r_b     <= {w_b_ext, 1'b0};
                        r_acc   <= {PW{1'b0}};
                        r_cnt   <= {CW{1'b0}};
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + CNT_ONE;
                    r_b   <= {2'b00, r_b[WIDTH+2:2]};
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth4_iter_mult.sv
// Directed self-checking bench for booth4_iter_mult (WIDTH = 16).
module tb_booth4_iter_mult;

    localparam int W = 16;

    logic           sys_clk = 1'b0;
    logic           sys_rst;
    logic           in_valid;
    logic           in_ready;
    logic           is_signed;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] prod;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int xfers  = 0;

    booth4_iter_mult #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) xfers <= xfers + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the negedge following the accept edge.
    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, output int acc_cyc);
        int n;
        @(negedge sys_clk);
        A = a; B = b; is_signed = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        if (!in_ready) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
        @(posedge sys_clk);
        acc_cyc = cyc;
        @(negedge sys_clk);
        in_valid = 1'b0;
        A = ~a; B = ~b;
    endtask

    // Latency counts the accept edge plus every edge up to the one raising out_valid.
    task automatic wait_valid(input string tag, output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge sys_clk);
            n++;
        end
        if (!out_valid) check({tag, "_valid_timeout"}, 64'd0, 64'd1);
        lat = n + 1;
    endtask

    task automatic finish_op(input string tag, input logic [2*W-1:0] exp);
        check({tag, "_prod"}, 64'(prod), 64'(exp));
        out_ready = 1'b1;
        @(negedge sys_clk);
        out_ready = 1'b0;
        check({tag, "_ovalid_clr"}, 64'(out_valid), 64'd0);
        check({tag, "_iready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [2*W-1:0] exp);
        int c0;
        int lat;
        start_op(tag, a, b, s, c0);
        wait_valid(tag, lat);
        check({tag, "_latency"}, 64'(lat), 64'd10);
        finish_op(tag, exp);
    endtask

    initial begin : main
        int c1;
        int c2;
        int lat;
        int x0;
        logic [2*W-1:0] held;

        sys_rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b0;
        A = 16'h0000; B = 16'h0000;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_prod",      64'(prod),      64'd0);

        run_op("s_5c0b_x3",   16'h5C0B, 16'h0003, 1'b1, 32'h0001_1421);
        run_op("s_min_min",   16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        run_op("s_min_max",   16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
        run_op("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        run_op("s_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);

        // Backpressure: 0x0101 * 0x0202 = 0x20402, held for five cycles.
        start_op("bp", 16'h0101, 16'h0202, 1'b0, c1);
        check("bp_busy", 64'(busy), 64'd1);
        wait_valid("bp", lat);
        check("bp_latency", 64'(lat), 64'd10);
        held = prod;
        x0 = xfers;
        check("bp_prod_first", 64'(held), 64'h0002_0402);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            A = 16'(i * 16'h1111); B = ~A;
            @(negedge sys_clk);
            check("bp_prod_hold",  64'(prod),      64'(held));
            check("bp_ovalid_hold", 64'(out_valid), 64'd1);
            check("bp_iready_low", 64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        finish_op("bp", 32'h0002_0402);
        check("bp_one_xfer", 64'(xfers - x0), 64'd1);
        run_op("after_bp", 16'h0010, 16'h0020, 1'b0, 32'h0000_0200);

        // Reset abort with cnt = 4.
        x0 = xfers;
        start_op("abort", 16'h5C0B, 16'h0003, 1'b1, c1);
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("abort_busy",   64'(busy),      64'd0);
        check("abort_ovalid", 64'(out_valid), 64'd0);
        check("abort_iready", 64'(in_ready),  64'd1);
        repeat (12) @(negedge sys_clk);
        check("abort_no_out", 64'(out_valid), 64'd0);
        check("abort_no_xfer", 64'(xfers - x0), 64'd0);
        run_op("zero_b", 16'h1234, 16'h0000, 1'b0, 32'h0000_0000);

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        start_op("b2b1", 16'h00FF, 16'h0010, 1'b0, c1);
        in_valid = 1'b1; A = 16'hFFFE; B = 16'h0005; is_signed = 1'b1;
        wait_valid("b2b1", lat);
        check("b2b1_latency", 64'(lat), 64'd10);
        check("b2b1_prod", 64'(prod), 64'h0000_0FF0);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge sys_clk);
            lat++;
        end
        @(posedge sys_clk);
        c2 = cyc;
        @(negedge sys_clk);
        in_valid = 1'b0;
        check("b2b_interval", 64'(c2 - c1), 64'd11);
        wait_valid("b2b2", lat);
        check("b2b2_latency", 64'(lat), 64'd10);
        check("b2b2_prod", 64'(prod), 64'hFFFF_FFF6);
        @(negedge sys_clk);
        check("b2b2_consumed", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
